// File: rtl/div_seq_pkg.sv
// Shared definitions for the MIX DIV sequencer: state encoding, MIX word geometry
// and the nominal divider latency.
package div_seq_pkg;

  localparam int MAG_W       = 30;
  localparam int SIGN_BIT    = 30;
  localparam int WORD_W      = 31;
  localparam int DIVIDEND_W  = 2 * MAG_W + 1;
  localparam int DIV_LATENCY = 12;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE
  } state_t;

  // Early overflow screen: |rA| >= |V| or V is a signed zero.
  function automatic logic fast_ovf_hit(input logic [WORD_W-1:0] ra,
                                        input logic [WORD_W-1:0] v);
    return (ra[MAG_W-1:0] >= v[MAG_W-1:0]) || (v[MAG_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/div_seq_wdog.sv
// Loadable down-counter shared by the post-reset drain and the divider watchdog.
// Holds at zero; expired is high whenever the count is zero.
module div_seq_wdog #(
  parameter int             W       = 5,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/div_seq.sv
// Sequencer between the execute stage and the 12-cycle MIX divider.
// Optional macro DIV_SEQ_FASTOVF_EN: resolve obvious overflows without starting the divider.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int TIMEOUT      = 16,
  parameter int DRAIN_CYCLES = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  output logic                  ready,
  input  logic [WORD_W-1:0]     ra_in,
  input  logic [WORD_W-1:0]     rx_in,
  input  logic [WORD_W-1:0]     v_in,
  output logic [WORD_W-1:0]     ra_out,
  output logic [WORD_W-1:0]     rx_out,
  output logic                  ra_we,
  output logic                  rx_we,
  output logic                  ovf_set,
  output logic                  done,
  output logic                  err,
  output logic                  div_start,
  output logic [DIVIDEND_W-1:0] div_dividend,
  output logic [WORD_W-1:0]     div_divisor,
  input  logic                  div_stop,
  input  logic [MAG_W-1:0]      div_quotient,
  input  logic [MAG_W-1:0]      div_rest,
  input  logic                  div_sign,
  input  logic                  div_overflow
);

  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Both counts end on the cycle the counter reads zero, hence the minus one.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(TIMEOUT - 1);

  state_t                  state_reg;
  logic                    ready_reg;
  logic                    done_reg;
  logic                    err_reg;
  logic                    ra_we_reg;
  logic                    rx_we_reg;
  logic                    ovf_set_reg;
  logic                    div_start_reg;
  logic [WORD_W-1:0]       ra_out_reg;
  logic [WORD_W-1:0]       rx_out_reg;
  logic [DIVIDEND_W-1:0]   dividend_reg;
  logic [WORD_W-1:0]       divisor_reg;
  logic                    saved_sign_reg;
  logic [MAG_W-1:0]        quot_reg;
  logic [MAG_W-1:0]        rest_reg;
  logic                    sign_reg;
  logic                    ovf_reg;

  logic                    wdog_load;
  logic                    wdog_en;
  logic                    wdog_expired;
  logic                    fast_ovf;
  logic                    unused_rx_sign;

  // rX sign never reaches the divider; the dividend sign comes from rA.
  assign unused_rx_sign = rx_in[SIGN_BIT];

`ifdef DIV_SEQ_FASTOVF_EN
  assign fast_ovf = fast_ovf_hit(ra_in, v_in);
`else
  assign fast_ovf = 1'b0;
`endif

  always_comb begin
    wdog_load = (state_reg == ST_LAUNCH);
    wdog_en   = (state_reg == ST_DRAIN) || (state_reg == ST_WAIT);
  end

  div_seq_wdog #(
    .W       (CNT_W),
    .RST_VAL (DRAIN_LOAD)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wdog_load),
    .load_val (WAIT_LOAD),
    .en       (wdog_en),
    .expired  (wdog_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_DRAIN;
      ready_reg      <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      ra_we_reg      <= 1'b0;
      rx_we_reg      <= 1'b0;
      ovf_set_reg    <= 1'b0;
      div_start_reg  <= 1'b0;
      ra_out_reg     <= '0;
      rx_out_reg     <= '0;
      dividend_reg   <= '0;
      divisor_reg    <= '0;
      saved_sign_reg <= 1'b0;
      quot_reg       <= '0;
      rest_reg       <= '0;
      sign_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      div_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      ra_we_reg     <= 1'b0;
      rx_we_reg     <= 1'b0;
      ovf_set_reg   <= 1'b0;

      case (state_reg)
        // Divider has no reset: let any run started before reset play out.
        ST_DRAIN: begin
          if (wdog_expired) begin
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (req && ready_reg) begin
            ready_reg      <= 1'b0;
            dividend_reg   <= {ra_in[SIGN_BIT], ra_in[MAG_W-1:0], rx_in[MAG_W-1:0]};
            divisor_reg    <= v_in;
            saved_sign_reg <= ra_in[SIGN_BIT];
            if (fast_ovf) begin
              ovf_reg   <= 1'b1;
              state_reg <= ST_WRITE;
            end else begin
              div_start_reg <= 1'b1;
              state_reg     <= ST_LAUNCH;
            end
          end
        end

        ST_LAUNCH: begin
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          if (div_stop) begin
            quot_reg  <= div_quotient;
            rest_reg  <= div_rest;
            sign_reg  <= div_sign;
            ovf_reg   <= div_overflow;
            state_reg <= ST_WRITE;
          end else if (wdog_expired) begin
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          done_reg  <= 1'b1;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
          if (ovf_reg) begin
            ovf_set_reg <= 1'b1;
            ra_out_reg  <= '0;
            rx_out_reg  <= '0;
          end else begin
            // Signs survive a zero magnitude, giving MIX -0 where due.
            ra_out_reg <= {sign_reg, quot_reg};
            rx_out_reg <= {saved_sign_reg, rest_reg};
            ra_we_reg  <= 1'b1;
            rx_we_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_DRAIN;
        end
      endcase
    end
  end

  assign ready        = ready_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign ra_we        = ra_we_reg;
  assign rx_we        = rx_we_reg;
  assign ovf_set      = ovf_set_reg;
  assign ra_out       = ra_out_reg;
  assign rx_out       = rx_out_reg;
  assign div_start    = div_start_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;

endmodule
